scariv_vlsu_load_merge: RTL and testbench

Vector LSU load-data merge stage that consumes L1D read responses for the requests produced by the vector address generator. It extracts the DLENB-byte register chunk from each cache-line response. For requests split across two cache lines, it holds the first half and merges in the second half at the register byte offset carried with the split request. It then delivers one registered write beat per vector step to the vector register file write port, with valid/ready backpressure.

---
 rtl/scariv_vlsu_load_merge.sv | 167 ++++++++++++++++
 tb/tb_scariv_vlsu_load_merge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_vlsu_load_merge.sv
// Vector LSU load-data merge: extracts a DLENB chunk from each L1D line,
// stitches line-crossing halves together and issues one write beat per step.
//
// Ports:
//   i_clk, i_reset_n        clock, async active-low reset
//   i_flush_valid           drop all in-flight state
//   i_resp_*, o_resp_ready  L1D load response (valid/ready)
//   o_wr_*, i_wr_ready      vector register write beat (valid/ready)
//   o_protocol_err          registered pulse on an illegal response sequence
module scariv_vlsu_load_merge #(
    parameter int DLENB           = 16,
    parameter int DCACHE_DATA_B_W = 32,
    parameter int VEC_POS_W       = 3
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic                               i_flush_valid,
    input  logic                               i_resp_valid,
    output logic                               o_resp_ready,
    input  logic [$clog2(DCACHE_DATA_B_W)-1:0] i_resp_vaddr_off,
    input  logic [DCACHE_DATA_B_W*8-1:0]       i_resp_data,
    input  logic                               i_resp_first_split,
    input  logic                               i_resp_splitted,
    input  logic [$clog2(DLENB)-1:0]           i_resp_reg_offset,
    input  logic [VEC_POS_W-1:0]               i_resp_vec_step_index,
    output logic                               o_wr_valid,
    input  logic                               i_wr_ready,
    output logic [DLENB*8-1:0]                 o_wr_data,
    output logic [DLENB-1:0]                   o_wr_be,
    output logic [VEC_POS_W-1:0]               o_wr_vec_step_index,
    output logic                               o_protocol_err
);

    localparam int OFF_W  = $clog2(DCACHE_DATA_B_W);
    localparam int ROFF_W = $clog2(DLENB);
    localparam int LINE_W = DCACHE_DATA_B_W * 8;
    localparam int CHNK_W = DLENB * 8;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_SECOND
    } state_t;

    state_t                 r_state, w_state_next;
    logic [CHNK_W-1:0]      r_hold, w_hold_next;
    logic [VEC_POS_W-1:0]   r_hold_step, w_hold_step_next;
    logic                   w_err_next;
    logic                   w_load;
    logic [CHNK_W-1:0]      w_load_data;
    logic [VEC_POS_W-1:0]   w_load_step;
    logic                   w_accept;

    // Bytes starting at off; past the line end either wrap or read as zero.
    function automatic logic [CHNK_W-1:0] f_extract(
        input logic [LINE_W-1:0] line,
        input logic [OFF_W-1:0]  off,
        input logic              zero_tail
    );
        logic [CHNK_W-1:0] r;
        int idx;
        r = '0;
        for (int j = 0; j < DLENB; j++) begin
            idx = int'(off) + j;
            if (idx >= DCACHE_DATA_B_W) begin
                if (zero_tail) r[8*j +: 8] = 8'h00;
                else r[8*j +: 8] = line[8*(idx-DCACHE_DATA_B_W) +: 8];
            end else begin
                r[8*j +: 8] = line[8*idx +: 8];
            end
        end
        return r;
    endfunction

    // Second-half line bytes land at reg_off and above; below comes from hold.
    function automatic logic [CHNK_W-1:0] f_merge(
        input logic [LINE_W-1:0] line,
        input logic [ROFF_W-1:0] reg_off,
        input logic [CHNK_W-1:0] hold
    );
        logic [CHNK_W-1:0] r;
        r = '0;
        for (int j = 0; j < DLENB; j++) begin
            if (j >= int'(reg_off))
                r[8*j +: 8] = line[8*(j-int'(reg_off)) +: 8];
            else
                r[8*j +: 8] = hold[8*j +: 8];
        end
        return r;
    endfunction

    assign o_resp_ready = ~i_flush_valid & (~o_wr_valid | i_wr_ready);
    assign w_accept     = i_resp_valid & o_resp_ready;

    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_hold_step_next = r_hold_step;
        w_err_next       = 1'b0;
        w_load           = 1'b0;
        w_load_data      = '0;
        w_load_step      = '0;
        if (i_flush_valid) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
        end else if (w_accept) begin
            if (i_resp_first_split & i_resp_splitted) begin
                w_err_next = 1'b1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (i_resp_splitted) begin
                            w_err_next = 1'b1;
                        end else if (i_resp_first_split) begin
                            w_hold_next      = f_extract(i_resp_data, i_resp_vaddr_off, 1'b1);
                            w_hold_step_next = i_resp_vec_step_index;
                            w_state_next     = WAIT_SECOND;
                        end else begin
                            w_load      = 1'b1;
                            w_load_data = f_extract(i_resp_data, i_resp_vaddr_off, 1'b0);
                            w_load_step = i_resp_vec_step_index;
                        end
                    end
                    WAIT_SECOND: begin
                        if (i_resp_splitted) begin
                            w_load       = 1'b1;
                            w_load_data  = f_merge(i_resp_data, i_resp_reg_offset, r_hold);
                            w_load_step  = r_hold_step;
                            w_state_next = IDLE;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    default: w_state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state             <= IDLE;
            r_hold              <= '0;
            r_hold_step         <= '0;
            o_protocol_err      <= 1'b0;
            o_wr_valid          <= 1'b0;
            o_wr_data           <= '0;
            o_wr_be             <= '0;
            o_wr_vec_step_index <= '0;
        end else begin
            r_state        <= w_state_next;
            r_hold         <= w_hold_next;
            r_hold_step    <= w_hold_step_next;
            o_protocol_err <= w_err_next;
            if (i_flush_valid) begin
                o_wr_valid <= 1'b0;
            end else if (w_load) begin
                o_wr_valid          <= 1'b1;
                o_wr_data           <= w_load_data;
                o_wr_be             <= '1;
                o_wr_vec_step_index <= w_load_step;
            end else if (i_wr_ready) begin
                o_wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scariv_vlsu_load_merge.sv
// Directed bench for scariv_vlsu_load_merge.
// Checks aligned, split, backpressure, protocol error, flush, async reset.
module tb_scariv_vlsu_load_merge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         rv;
    logic         rrdy;
    logic [4:0]   roff;
    logic [255:0] rdata;
    logic         rfirst;
    logic         rsplit;
    logic [3:0]   rreg;
    logic [2:0]   rstep;
    logic         wv;
    logic         wrdy;
    logic [127:0] wdata;
    logic [15:0]  wbe;
    logic [2:0]   wstep;
    logic         perr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scariv_vlsu_load_merge #(
        .DLENB(16), .DCACHE_DATA_B_W(32), .VEC_POS_W(3)
    ) dut (
        .i_clk                (clk),
        .i_reset_n            (rst_n),
        .i_flush_valid        (flush),
        .i_resp_valid         (rv),
        .o_resp_ready         (rrdy),
        .i_resp_vaddr_off     (roff),
        .i_resp_data          (rdata),
        .i_resp_first_split   (rfirst),
        .i_resp_splitted      (rsplit),
        .i_resp_reg_offset    (rreg),
        .i_resp_vec_step_index(rstep),
        .o_wr_valid           (wv),
        .i_wr_ready           (wrdy),
        .o_wr_data            (wdata),
        .o_wr_be              (wbe),
        .o_wr_vec_step_index  (wstep),
        .o_protocol_err       (perr)
    );

    localparam logic [127:0] D_10 = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] D_SP = 128'h87868584838281801f1e1d1c1b1a1918;
    localparam logic [127:0] D_00 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] D_04 = 128'h131211100f0e0d0c0b0a090807060504;

    function automatic logic [255:0] mkline(input logic [7:0] base);
        logic [255:0] l;
        for (int k = 0; k < 32; k++) l[8*k +: 8] = base + 8'(k);
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] off,
                         input logic [7:0] base, input logic f,
                         input logic s, input logic [3:0] ro,
                         input logic [2:0] st);
        rv     = v;
        roff   = off;
        rdata  = mkline(base);
        rfirst = f;
        rsplit = s;
        rreg   = ro;
        rstep  = st;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wrdy  = 1'b1;
        idle();
        #12;
        check("rst_valid", 128'(wv), 128'(0));
        check("rst_err",   128'(perr), 128'(0));
        check("rst_data",  wdata, 128'(0));
        check("rst_be",    128'(wbe), 128'(0));
        check("rst_step",  128'(wstep), 128'(0));
        check("rst_ready", 128'(rrdy), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // aligned
        drive(1'b1, 5'h10, 8'h00, 1'b0, 1'b0, 4'd0, 3'd2);
        tick();
        idle();
        check("al_valid", 128'(wv), 128'(1));
        check("al_data",  wdata, D_10);
        check("al_be",    128'(wbe), 128'hffff);
        check("al_step",  128'(wstep), 128'(2));
        tick();
        check("al_drain", 128'(wv), 128'(0));

        // split pair with 3-cycle gap
        drive(1'b1, 5'h18, 8'h00, 1'b1, 1'b0, 4'd0, 3'd5);
        tick();
        idle();
        check("sp_first_nobeat", 128'(wv), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sp_gap_nobeat", 128'(wv), 128'(0));
        end
        drive(1'b1, 5'h00, 8'h80, 1'b0, 1'b1, 4'd8, 3'd0);
        tick();
        idle();
        check("sp_valid", 128'(wv), 128'(1));
        check("sp_data",  wdata, D_SP);
        check("sp_step",  128'(wstep), 128'(5));
        check("sp_err",   128'(perr), 128'(0));
        tick();
        check("sp_one_beat", 128'(wv), 128'(0));

        // backpressure
        wrdy = 1'b0;
        drive(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 4'd0, 3'd1);
        tick();
        drive(1'b1, 5'h04, 8'h00, 1'b0, 1'b0, 4'd0, 3'd3);
        #1;
        check("bp_valid", 128'(wv), 128'(1));
        check("bp_data",  wdata, D_00);
        check("bp_ready_low", 128'(rrdy), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", wdata, D_00);
            check("bp_hold_step", 128'(wstep), 128'(1));
            check("bp_hold_valid", 128'(wv), 128'(1));
        end
        wrdy = 1'b1;
        #1;
        check("bp_ready_high", 128'(rrdy), 128'(1));
        tick();
        idle();
        check("bp_b_valid", 128'(wv), 128'(1));
        check("bp_b_data",  wdata, D_04);
        check("bp_b_step",  128'(wstep), 128'(3));
        tick();
        check("bp_drain", 128'(wv), 128'(0));

        // protocol error: splitted in IDLE
        drive(1'b1, 5'h00, 8'h40, 1'b0, 1'b1, 4'd4, 3'd7);
        tick();
        idle();
        check("pe_pulse",  128'(perr), 128'(1));
        check("pe_nobeat", 128'(wv), 128'(0));
        tick();
        check("pe_clear", 128'(perr), 128'(0));
        check("pe_nobeat2", 128'(wv), 128'(0));
        drive(1'b1, 5'h10, 8'h00, 1'b0, 1'b0, 4'd0, 3'd6);
        tick();
        idle();
        check("pe_al_valid", 128'(wv), 128'(1));
        check("pe_al_data",  wdata, D_10);
        check("pe_al_step",  128'(wstep), 128'(6));
        tick();

        // flush with a pending beat
        wrdy = 1'b0;
        drive(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 4'd0, 3'd1);
        tick();
        drive(1'b1, 5'h04, 8'h00, 1'b0, 1'b0, 4'd0, 3'd2);
        flush = 1'b1;
        #1;
        check("fl_ready_low", 128'(rrdy), 128'(0));
        tick();
        flush = 1'b0;
        idle();
        wrdy = 1'b1;
        check("fl_valid_drop", 128'(wv), 128'(0));
        check("fl_no_err", 128'(perr), 128'(0));
        tick();
        check("fl_not_accepted", 128'(wv), 128'(0));

        // flush in WAIT_SECOND, then orphan second half
        drive(1'b1, 5'h18, 8'h00, 1'b1, 1'b0, 4'd0, 3'd4);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_ws_noerr", 128'(perr), 128'(0));
        drive(1'b1, 5'h00, 8'h80, 1'b0, 1'b1, 4'd8, 3'd0);
        tick();
        idle();
        check("fl_ws_err", 128'(perr), 128'(1));
        check("fl_ws_nobeat", 128'(wv), 128'(0));
        tick();

        // async reset mid-WAIT_SECOND with nonzero output regs
        drive(1'b1, 5'h18, 8'h00, 1'b1, 1'b0, 4'd0, 3'd5);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 128'(wv), 128'(0));
        check("ar_data",  wdata, 128'(0));
        check("ar_be",    128'(wbe), 128'(0));
        check("ar_step",  128'(wstep), 128'(0));
        check("ar_err",   128'(perr), 128'(0));
        #3;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 5'h10, 8'h00, 1'b0, 1'b0, 4'd0, 3'd2);
        tick();
        idle();
        check("ar_al_valid", 128'(wv), 128'(1));
        check("ar_al_data",  wdata, D_10);
        check("ar_al_step",  128'(wstep), 128'(2));
        tick();
        drive(1'b1, 5'h00, 8'h80, 1'b0, 1'b1, 4'd8, 3'd0);
        tick();
        idle();
        check("ar_idle_err", 128'(perr), 128'(1));
        check("ar_idle_nobeat", 128'(wv), 128'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
